// File: rtl/vx_stream_rr_arbiter.sv
// Round-robin stream arbiter: NUM_REQS valid/ready inputs merged onto one output,
// with an optional one-entry bypass buffer. Define VX_STREAM_ARB_PERF_EN for stall/grant counters.
module vx_stream_rr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 1,
    parameter int BUFFERED = 1,
    localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out
`ifdef VX_STREAM_ARB_PERF_EN
    ,
    output logic [31:0]               perf_stalls,
    output logic [NUM_REQS*32-1:0]    perf_grants
`endif
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_idx;
    logic            rr_found;
    logic [SELW-1:0] cand;

    logic [SELW-1:0] grant_idx;
    logic            grant_valid;
    logic            accept;

    // First valid requester at or after ptr, wrapping modulo NUM_REQS.
    always_comb begin
        rr_idx   = ptr;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = SELW'((int'(ptr) + k) % NUM_REQS);
            if (!rr_found && valid_in[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    generate
        if (BUFFERED == 0) begin : g_direct
            logic            lock_valid;
            logic [SELW-1:0] lock_idx;

            // A stalled grant is pinned so the output stays stable until it is taken.
            assign grant_idx   = lock_valid ? lock_idx : rr_idx;
            assign grant_valid = lock_valid ? valid_in[lock_idx] : rr_found;
            assign accept      = grant_valid && ready_out && !reset;

            assign valid_out = grant_valid && !reset;
            assign data_out  = data_in[grant_idx*DATAW +: DATAW];
            assign sel_out   = grant_idx;

            always_ff @(posedge clk) begin
                if (reset) begin
                    lock_valid <= 1'b0;
                end else begin
                    lock_valid <= valid_out && !ready_out;
                end
                lock_idx <= grant_idx;
            end
        end else begin : g_buffered
            logic             buf_valid;
            logic [DATAW-1:0] buf_data;
            logic [SELW-1:0]  buf_sel;
            logic             capture;

            assign grant_idx   = rr_idx;
            assign grant_valid = rr_found;
            assign accept      = grant_valid && (ready_out || !buf_valid) && !reset;

            // A transfer accepted while the buffer drains refills it, so nothing accepted is lost.
            assign capture = accept && (!ready_out || buf_valid);

            assign valid_out = !reset && (buf_valid || grant_valid);
            assign data_out  = buf_valid ? buf_data : data_in[grant_idx*DATAW +: DATAW];
            assign sel_out   = buf_valid ? buf_sel : grant_idx;

            always_ff @(posedge clk) begin
                if (reset) begin
                    buf_valid <= 1'b0;
                end else if (capture) begin
                    buf_valid <= 1'b1;
                end else if (ready_out) begin
                    buf_valid <= 1'b0;
                end
            end

            // Payload storage is deliberately left out of reset; only buf_valid qualifies it.
            always_ff @(posedge clk) begin
                if (capture) begin
                    buf_data <= data_in[grant_idx*DATAW +: DATAW];
                    buf_sel  <= grant_idx;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    no_overwrite: assert (!(capture && buf_valid && !ready_out));
                end
            end
        end
    endgenerate

    always_comb begin
        ready_in = '0;
        if (accept) begin
            ready_in[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= SELW'((int'(grant_idx) + 1) % NUM_REQS);
        end
    end

`ifdef VX_STREAM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls <= '0;
            perf_grants <= '0;
        end else begin
            if (valid_out && !ready_out) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                if (valid_in[i] && ready_in[i]) begin
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_stream_rr_arbiter.sv
// Self-checking bench: one buffered and one unbuffered 4-requester arbiter,
// directed scenarios plus randomized traffic against a queue-based reference model.
module tb_vx_stream_rr_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  b_valid_in, n_valid_in;
    logic [31:0] b_data_in, n_data_in;
    logic [3:0]  b_ready_in, n_ready_in;
    logic        b_valid_out, n_valid_out;
    logic [7:0]  b_data_out, n_data_out;
    logic [1:0]  b_sel_out, n_sel_out;
    logic        b_ready_out, n_ready_out;
`ifdef VX_STREAM_ARB_PERF_EN
    logic [31:0]  b_perf_stalls, n_perf_stalls;
    logic [127:0] b_perf_grants, n_perf_grants;
`endif

    int checks = 0;
    int failures = 0;

    vx_stream_rr_arbiter #(.NUM_REQS(4), .DATAW(8), .BUFFERED(1)) u_buf (
        .clk(clk), .reset(reset),
        .valid_in(b_valid_in), .data_in(b_data_in), .ready_in(b_ready_in),
        .valid_out(b_valid_out), .data_out(b_data_out), .sel_out(b_sel_out),
        .ready_out(b_ready_out)
`ifdef VX_STREAM_ARB_PERF_EN
        , .perf_stalls(b_perf_stalls), .perf_grants(b_perf_grants)
`endif
    );

    vx_stream_rr_arbiter #(.NUM_REQS(4), .DATAW(8), .BUFFERED(0)) u_nb (
        .clk(clk), .reset(reset),
        .valid_in(n_valid_in), .data_in(n_data_in), .ready_in(n_ready_in),
        .valid_out(n_valid_out), .data_out(n_data_out), .sel_out(n_sel_out),
        .ready_out(n_ready_out)
`ifdef VX_STREAM_ARB_PERF_EN
        , .perf_stalls(n_perf_stalls), .perf_grants(n_perf_grants)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b_valid_in = '0; b_data_in = '0; b_ready_out = 1'b0;
        n_valid_in = '0; n_data_in = '0; n_ready_out = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        b_ready_out = 1'b1;
        n_ready_out = 1'b1;
        next_cycle();
        #1;
        checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL rst_b_valid got=%b exp=0", b_valid_out); end
        checks++; if (b_ready_in !== 4'b0) begin failures++; $display("FAIL rst_b_ready got=%b exp=0000", b_ready_in); end
        checks++; if (n_valid_out !== 1'b0) begin failures++; $display("FAIL rst_n_valid got=%b exp=0", n_valid_out); end
        checks++; if (n_ready_in !== 4'b0) begin failures++; $display("FAIL rst_n_ready got=%b exp=0000", n_ready_in); end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL post_rst_b_valid got=%b exp=0", b_valid_out); end
        checks++; if (n_valid_out !== 1'b0) begin failures++; $display("FAIL post_rst_n_valid got=%b exp=0", n_valid_out); end
    endtask

    task automatic test_rr_all_valid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b_data_in[i*8 +: 8] = 8'h10 + 8'(i);
            n_data_in[i*8 +: 8] = 8'h10 + 8'(i);
        end
        b_valid_in = 4'hF; n_valid_in = 4'hF;
        b_ready_out = 1'b1; n_ready_out = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (n_sel_out !== 2'(c % 4)) begin failures++; $display("FAIL rr_n_sel cyc=%0d got=%0d exp=%0d", c, n_sel_out, c % 4); end
            checks++; if (n_data_out !== 8'h10 + 8'(c % 4)) begin failures++; $display("FAIL rr_n_data cyc=%0d got=%h exp=%h", c, n_data_out, 8'h10 + 8'(c % 4)); end
            checks++; if (n_ready_in !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_n_ready cyc=%0d got=%b", c, n_ready_in); end
            checks++; if (b_sel_out !== 2'(c % 4)) begin failures++; $display("FAIL rr_b_sel cyc=%0d got=%0d exp=%0d", c, b_sel_out, c % 4); end
            next_cycle();
        end
    endtask

    task automatic test_sparse();
        int exp_g[3] = '{1, 3, 1};
        do_reset();
        n_valid_in = 4'b1010;
        n_ready_out = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (n_sel_out !== 2'(exp_g[c])) begin failures++; $display("FAIL sparse_sel cyc=%0d got=%0d exp=%0d", c, n_sel_out, exp_g[c]); end
            checks++; if (n_ready_in !== 4'(1 << exp_g[c])) begin failures++; $display("FAIL sparse_ready cyc=%0d got=%b", c, n_ready_in); end
            next_cycle();
        end
    endtask

    task automatic test_buffer_capture();
        do_reset();
        b_data_in[16 +: 8] = 8'h5A;
        b_valid_in = 4'b0100;
        b_ready_out = 1'b0;
        #1;
        checks++; if (b_ready_in !== 4'b0100) begin failures++; $display("FAIL cap_ready got=%b exp=0100", b_ready_in); end
        checks++; if (b_data_out !== 8'h5A) begin failures++; $display("FAIL cap_bypass_data got=%h exp=5a", b_data_out); end
        next_cycle();
        b_valid_in = 4'b0001;
        b_data_in[0 +: 8] = 8'h33;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (b_ready_in !== 4'b0000) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=0000", c, b_ready_in); end
            checks++; if (b_valid_out !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, b_valid_out); end
            checks++; if (b_data_out !== 8'h5A) begin failures++; $display("FAIL hold_data cyc=%0d got=%h exp=5a", c, b_data_out); end
            checks++; if (b_sel_out !== 2'd2) begin failures++; $display("FAIL hold_sel cyc=%0d got=%0d exp=2", c, b_sel_out); end
            next_cycle();
        end
        b_ready_out = 1'b1;
        #1;
        checks++; if (b_data_out !== 8'h5A) begin failures++; $display("FAIL drain_data got=%h exp=5a", b_data_out); end
        checks++; if (b_ready_in !== 4'b0001) begin failures++; $display("FAIL drain_ready got=%b exp=0001", b_ready_in); end
        next_cycle();
        b_valid_in = 4'b0000;
        #1;
        checks++; if (b_valid_out !== 1'b1 || b_data_out !== 8'h33 || b_sel_out !== 2'd0) begin
            failures++; $display("FAIL refill got v=%b d=%h s=%0d exp v=1 d=33 s=0", b_valid_out, b_data_out, b_sel_out);
        end
        next_cycle();
        #1;
        checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", b_valid_out); end
    endtask

    task automatic test_lock();
        do_reset();
        n_data_in[24 +: 8] = 8'h77;
        n_data_in[0 +: 8]  = 8'h11;
        n_valid_in = 4'b1000;
        n_ready_out = 1'b0;
        #1;
        checks++; if (n_sel_out !== 2'd3) begin failures++; $display("FAIL lock_first_sel got=%0d exp=3", n_sel_out); end
        next_cycle();
        n_valid_in = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (n_sel_out !== 2'd3 || n_data_out !== 8'h77) begin failures++; $display("FAIL lock_hold cyc=%0d got s=%0d d=%h exp s=3 d=77", c, n_sel_out, n_data_out); end
            checks++; if (n_ready_in !== 4'b0000) begin failures++; $display("FAIL lock_ready cyc=%0d got=%b exp=0000", c, n_ready_in); end
            next_cycle();
        end
        n_ready_out = 1'b1;
        #1;
        checks++; if (n_ready_in !== 4'b1000) begin failures++; $display("FAIL lock_release got=%b exp=1000", n_ready_in); end
        next_cycle();
        n_valid_in = 4'b0001;
        #1;
        checks++; if (n_sel_out !== 2'd0 || n_data_out !== 8'h11) begin failures++; $display("FAIL lock_next got s=%0d d=%h exp s=0 d=11", n_sel_out, n_data_out); end
        next_cycle();
    endtask

    task automatic test_reset_midstall();
        do_reset();
        b_data_in[8 +: 8] = 8'hC3;
        b_valid_in = 4'b0010;
        b_ready_out = 1'b0;
        next_cycle();
        b_valid_in = 4'b0000;
        #1;
        checks++; if (b_valid_out !== 1'b1 || b_data_out !== 8'hC3) begin failures++; $display("FAIL midstall_full got v=%b d=%h exp v=1 d=c3", b_valid_out, b_data_out); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL midstall_cleared got=%b exp=0", b_valid_out); end
        b_ready_out = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (b_valid_out !== 1'b0) begin failures++; $display("FAIL midstall_no_emit cyc=%0d got=%b exp=0", c, b_valid_out); end
            next_cycle();
        end
        b_valid_in = 4'hF;
        #1;
        checks++; if (b_sel_out !== 2'd0) begin failures++; $display("FAIL midstall_ptr got=%0d exp=0", b_sel_out); end
        next_cycle();
    endtask

    task automatic test_random_buffered();
        bit       pend[4];
        bit [7:0] pdata[4];
        int       q[$];
        int       mptr = 0;
        do_reset();
        for (int i = 0; i < 4; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            int g, item;
            bit ro, exp_vo, qempty0;
            logic [3:0] exp_rdy;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 50) begin
                    pend[i] = 1;
                    pdata[i] = 8'($urandom);
                end
                b_valid_in[i] = pend[i];
                b_data_in[i*8 +: 8] = pdata[i];
            end
            ro = ($urandom_range(0, 99) < 60);
            b_ready_out = ro;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && pend[(mptr + k) % 4]) g = (mptr + k) % 4;
            end
            qempty0 = (q.size() == 0);
            exp_rdy = (g >= 0 && (ro || qempty0)) ? 4'(1 << g) : 4'b0;
            exp_vo = !qempty0 || g >= 0;
            item = qempty0 ? ((g << 8) | int'(pdata[g < 0 ? 0 : g])) : q[0];
            #1;
            checks++; if (b_ready_in !== exp_rdy) begin failures++; $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", c, b_ready_in, exp_rdy); end
            checks++; if (b_valid_out !== exp_vo) begin failures++; $display("FAIL rnd_b_valid cyc=%0d got=%b exp=%b", c, b_valid_out, exp_vo); end
            if (exp_vo) begin
                checks++; if ({6'b0, b_sel_out, b_data_out} !== 16'(item)) begin
                    failures++; $display("FAIL rnd_b_out cyc=%0d got s=%0d d=%h exp s=%0d d=%h", c, b_sel_out, b_data_out, item >> 8, item & 255);
                end
            end
            if (exp_vo && ro && !qempty0) void'(q.pop_front());
            if (exp_rdy != 0) begin
                if (!qempty0 || !ro) q.push_back((g << 8) | int'(pdata[g]));
                pend[g] = 0;
                mptr = (g + 1) % 4;
            end
            next_cycle();
        end
        b_valid_in = '0;
    endtask

    task automatic test_random_unbuffered();
        bit       pend[4];
        bit [7:0] pdata[4];
        int       held = -1;
        int       mptr = 0;
        do_reset();
        for (int i = 0; i < 4; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            int g;
            bit ro;
            logic [3:0] exp_rdy;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1;
                    pdata[i] = 8'($urandom);
                end
                n_valid_in[i] = pend[i];
                n_data_in[i*8 +: 8] = pdata[i];
            end
            ro = ($urandom_range(0, 99) < 55);
            n_ready_out = ro;
            g = held;
            if (g < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && pend[(mptr + k) % 4]) g = (mptr + k) % 4;
                end
            end
            exp_rdy = (g >= 0 && ro) ? 4'(1 << g) : 4'b0;
            #1;
            checks++; if (n_ready_in !== exp_rdy) begin failures++; $display("FAIL rnd_n_ready cyc=%0d got=%b exp=%b", c, n_ready_in, exp_rdy); end
            checks++; if (n_valid_out !== (g >= 0)) begin failures++; $display("FAIL rnd_n_valid cyc=%0d got=%b exp=%b", c, n_valid_out, g >= 0); end
            if (g >= 0) begin
                checks++; if (n_sel_out !== 2'(g) || n_data_out !== pdata[g]) begin
                    failures++; $display("FAIL rnd_n_out cyc=%0d got s=%0d d=%h exp s=%0d d=%h", c, n_sel_out, n_data_out, g, pdata[g]);
                end
            end
            held = (g >= 0 && !ro) ? g : -1;
            if (exp_rdy != 0) begin
                pend[g] = 0;
                mptr = (g + 1) % 4;
            end
            next_cycle();
        end
        n_valid_in = '0;
    endtask

`ifdef VX_STREAM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        n_valid_in = 4'b0010;
        n_ready_out = 1'b0;
        repeat (5) next_cycle();
        n_ready_out = 1'b1;
        repeat (3) next_cycle();
        n_valid_in = 4'b0000;
        #1;
        checks++; if (n_perf_stalls !== 32'd5) begin failures++; $display("FAIL perf_stalls got=%0d exp=5", n_perf_stalls); end
        checks++; if (n_perf_grants[32 +: 32] !== 32'd3) begin failures++; $display("FAIL perf_grant1 got=%0d exp=3", n_perf_grants[32 +: 32]); end
        checks++; if (n_perf_grants[0 +: 32] !== 32'd0) begin failures++; $display("FAIL perf_grant0 got=%0d exp=0", n_perf_grants[0 +: 32]); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_rr_all_valid();
        test_sparse();
        test_buffer_capture();
        test_lock();
        test_reset_midstall();
        test_random_buffered();
        test_random_unbuffered();
`ifdef VX_STREAM_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
